// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entries carry a PC slot sized for the widest supported program counter.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int IMEM_AW  = 6;
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
  } fetch_entry_t;

  // Occupancy after one cycle of queue activity.
  function automatic int unsigned next_count(input int unsigned cnt, input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return cnt + 32'd1;
      2'b01:   return cnt - 32'd1;
      default: return cnt;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {instr, pc} entries with flush; head is presented from
// registered state and reads as zero while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic         o_full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t      r_mem [QDEPTH];
  logic [QDEPTH-1:0] r_vld;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_do_pop;
  logic w_do_push;
  logic w_full;

  assign w_full    = (r_count == CW'(QDEPTH));
  assign w_do_pop  = i_pop & r_vld[r_rd_ptr];
  // A pop on a full queue frees the slot the push writes into.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage, per-entry valid bits, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_vld    <= {QDEPTH{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_vld    <= {QDEPTH{1'b0}};
    end else begin
      if (w_do_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1'b1);
      end
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
      end
      r_count <= CW'(next_count(32'(r_count), w_do_push, w_do_pop));
    end
  end

  // Head presentation, zeroed when no valid entry is at the read pointer.
  always_comb begin
    o_valid = r_vld[r_rd_ptr];
    if (o_valid) begin
      o_head = r_mem[r_rd_ptr];
    end else begin
      o_head = '0;
    end
  end

  assign o_full = w_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect handling and a fetch queue.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N      = 64,
  parameter int QDEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [N-1:0]       if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [N-1:0] PC_STEP    = N'(3'd4);
  localparam logic [N-1:0] ALIGN_MASK = ~(N'(2'd3));

  logic [N-1:0]  r_pc;
  logic [N-1:0]  w_pc_nxt;
  logic          w_q_valid;
  logic          w_q_full;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_push;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  assign w_pop_req = w_q_valid & if_ready;
  // A redirect discards whatever the consumer accepts in the same cycle.
  assign w_pop     = w_pop_req & ~br_taken;
  assign w_push    = ~br_taken & (~w_q_full | w_pop);

  assign w_entry.instr = imem_q;
  assign w_entry.pc    = PC_MAX_W'(r_pc);

  // Next program counter: redirect, sequential advance, or hold.
  always_comb begin
    w_pc_nxt = r_pc;
    if (br_taken) begin
      w_pc_nxt = br_target & ALIGN_MASK;
    end else if (w_push) begin
      w_pc_nxt = r_pc + PC_STEP;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= {N{1'b0}};
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (br_taken),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_valid (w_q_valid),
    .o_full  (w_q_full)
  );

  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign if_valid  = w_q_valid;
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc[N-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Push and full-stall counters; only reset clears them, redirects do not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_q_full && !w_pop_req) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch rules.
module tb_fetch_stage;

  localparam int N  = 64;
  localparam int QD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    imem_addr;
  logic [31:0]   imem_q;
  logic          br_taken = 1'b0;
  logic [N-1:0]  br_target = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [31:0]   if_instr;
  logic [N-1:0]  if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  logic [31:0] imem [64];
  assign imem_q = imem[imem_addr];

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ment_t;

  ment_t       mq[$];
  logic [63:0] m_pc;
  int unsigned m_fetched;
  int unsigned m_stall;
  int          errors = 0;
  int          checks = 0;

  fetch_stage #(.N(N), .QDEPTH(QD)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_pc      = 64'd0;
    m_fetched = 0;
    m_stall   = 0;
  endtask

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0].instr : 32'd0;
  endfunction

  function automatic logic [63:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : 64'd0;
  endfunction

  // One clock cycle of stimulus; the model applies the same cycle's rules.
  task automatic tick(input logic rdy, input logic br, input logic [63:0] tgt);
    logic full, pop, push;
    if_ready  = rdy;
    br_taken  = br;
    br_target = tgt;
    full = (mq.size() == QD);
    pop  = (mq.size() != 0) && rdy;
    push = 1'b0;
    if (full && !pop) m_stall++;
    if (br) begin
      mq.delete();
      m_pc = {tgt[63:2], 2'b00};
    end else begin
      push = !full || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{instr: imem[m_pc[7:2]], pc: m_pc});
        m_pc = m_pc + 64'd4;
        m_fetched++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_instr); end
    if (if_pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
    if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    tick(1'b1, 1'b0, 64'd0);
    checks += 3;
    if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid0: got %b expected 1", if_valid); end
    if (if_instr !== 32'hf8000000) begin errors++; $display("FAIL stream_instr0: got %h expected f8000000", if_instr); end
    if (if_pc !== 64'd0) begin errors++; $display("FAIL stream_pc0: got %h expected 0", if_pc); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_instr !== 32'hf8008001) begin errors++; $display("FAIL stream_instr1: got %h expected f8008001", if_instr); end
    if (if_pc !== 64'd4) begin errors++; $display("FAIL stream_pc1: got %h expected 4", if_pc); end
    for (int i = 2; i < 12; i++) begin
      tick(1'b1, 1'b0, 64'd0);
      checks += 3;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: cycle %0d got %b expected 1", i, if_valid); end
      if (if_instr !== imem[i]) begin errors++; $display("FAIL stream_instr: cycle %0d got %h expected %h", i, if_instr, imem[i]); end
      if (if_pc !== 64'(i * 4)) begin errors++; $display("FAIL stream_pc: cycle %0d got %h expected %h", i, if_pc, 64'(i * 4)); end
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    repeat (6) tick(1'b0, 1'b0, 64'd0);
    checks += 3;
    if (imem_addr !== 6'd2) begin errors++; $display("FAIL stall_addr: got %0d expected 2", imem_addr); end
    if (if_instr !== 32'hf8000000) begin errors++; $display("FAIL stall_instr: got %h expected f8000000", if_instr); end
    if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", if_valid); end
`ifdef FETCH_PERF_EN
    checks += 2;
    if (perf_stall !== 32'd4) begin errors++; $display("FAIL stall_perf_stall: got %0d expected 4", perf_stall); end
    if (perf_fetched !== 32'd2) begin errors++; $display("FAIL stall_perf_fetched: got %0d expected 2", perf_fetched); end
`endif
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_instr !== 32'hf8008001) begin errors++; $display("FAIL stall_release1: got %h expected f8008001", if_instr); end
    if (if_pc !== 64'd4) begin errors++; $display("FAIL stall_release1_pc: got %h expected 4", if_pc); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_instr !== imem[2]) begin errors++; $display("FAIL stall_release2: got %h expected %h", if_instr, imem[2]); end
    if (if_pc !== 64'd8) begin errors++; $display("FAIL stall_release2_pc: got %h expected 8", if_pc); end
  endtask

  task automatic test_redirect();
    pulse_reset();
    repeat (2) tick(1'b0, 1'b0, 64'd0);
    tick(1'b1, 1'b1, 64'h3B);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush: got %b expected 0", if_valid); end
    if (imem_addr !== 6'd14) begin errors++; $display("FAIL redirect_addr: got %0d expected 14", imem_addr); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_instr !== 32'hcb0e01ce) begin errors++; $display("FAIL redirect_instr: got %h expected cb0e01ce", if_instr); end
    if (if_pc !== 64'h38) begin errors++; $display("FAIL redirect_pc: got %h expected 38", if_pc); end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b1, 64'hFC);
    checks += 1;
    if (imem_addr !== 6'd63) begin errors++; $display("FAIL wrap_addr0: got %0d expected 63", imem_addr); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (imem_addr !== 6'd0) begin errors++; $display("FAIL wrap_addr1: got %0d expected 0", imem_addr); end
    if (if_pc !== 64'hFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fc", if_pc); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (imem_addr !== 6'd1) begin errors++; $display("FAIL wrap_addr2: got %0d expected 1", imem_addr); end
    if (if_pc !== 64'h100) begin errors++; $display("FAIL wrap_pc1: got %h expected 100", if_pc); end
    tick(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top_pc: got %h expected fffffffffffffffc", if_pc); end
    if (imem_addr !== 6'd0) begin errors++; $display("FAIL wrap_top_addr: got %0d expected 0", imem_addr); end
    tick(1'b1, 1'b0, 64'd0);
    checks += 1;
    if (if_pc !== 64'd0) begin errors++; $display("FAIL wrap_top_next: got %h expected 0", if_pc); end
  endtask

  task automatic test_reset_midop();
    tick(1'b0, 1'b1, 64'h18);
    repeat (2) tick(1'b0, 1'b0, 64'd0);
    checks += 2;
    if (imem_addr !== 6'd8) begin errors++; $display("FAIL midop_pre_addr: got %0d expected 8", imem_addr); end
    if (if_valid !== 1'b1) begin errors++; $display("FAIL midop_pre_valid: got %b expected 1", if_valid); end
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b expected 0", if_valid); end
    if (imem_addr !== 6'd0) begin errors++; $display("FAIL midop_addr: got %0d expected 0", imem_addr); end
    if (if_instr !== 32'd0) begin errors++; $display("FAIL midop_instr: got %h expected 0", if_instr); end
    reset = 1'b1;
    tick(1'b1, 1'b0, 64'd0);
    checks += 2;
    if (if_instr !== 32'hf8000000) begin errors++; $display("FAIL midop_after_instr: got %h expected f8000000", if_instr); end
    if (if_pc !== 64'd0) begin errors++; $display("FAIL midop_after_pc: got %h expected 0", if_pc); end
  endtask

  task automatic test_random();
    logic        rdy, br;
    logic [63:0] tgt;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      tgt = {$urandom, $urandom};
      tick(rdy, br, tgt);
      checks += 4;
      if (if_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", i, if_valid, exp_valid()); end
      if (if_instr !== exp_instr()) begin errors++; $display("FAIL rand_instr: cycle %0d got %h expected %h", i, if_instr, exp_instr()); end
      if (if_pc !== exp_pc()) begin errors++; $display("FAIL rand_pc: cycle %0d got %h expected %h", i, if_pc, exp_pc()); end
      if (imem_addr !== m_pc[7:2]) begin errors++; $display("FAIL rand_addr: cycle %0d got %0d expected %0d", i, imem_addr, m_pc[7:2]); end
    end
`ifdef FETCH_PERF_EN
    checks += 2;
    if (perf_fetched !== m_fetched) begin errors++; $display("FAIL rand_perf_fetched: got %0d expected %0d", perf_fetched, m_fetched); end
    if (perf_stall !== m_stall) begin errors++; $display("FAIL rand_perf_stall: got %0d expected %0d", perf_stall, m_stall); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0]  = 32'hf8000000;
    imem[1]  = 32'hf8008001;
    imem[14] = 32'hcb0e01ce;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
